// File: rtl/imgfilt_pkg.sv
// imgfilt_pkg: shared state encoding and beat arithmetic for the frame streamer.
package imgfilt_pkg;

    typedef enum logic [2:0] {IDLE, SOF, LINE, HBLANK, DONE} stream_state_t;

    function automatic logic [15:0] beats_per_line(input logic [15:0] col_size, input logic [15:0] pix);
        logic [16:0] sum;
        sum = {1'b0, col_size} + {1'b0, pix} - 17'd1;
        return 16'(sum / {1'b0, pix});
    endfunction

endpackage

// File: rtl/frame_streamer.sv
// frame_streamer: pulls packed pixel words upstream and frames them as rows x beats
// with programmable horizontal blanking for the filter chain.
module frame_streamer
    import imgfilt_pkg::*;
#(
    parameter int DWIDTH   = 10,
    parameter int PIXCNT   = 8,
    parameter int ROWS     = 2048,
    parameter int COLS     = 2448,
    parameter int HB_WIDTH = 8
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       start,
    input  logic [$clog2(ROWS)-1:0]    rowSize,
    input  logic [$clog2(COLS)-1:0]    colSize,
    input  logic [HB_WIDTH-1:0]        hblank,
    input  logic [DWIDTH*PIXCNT-1:0]   s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       new_frame,
    output logic [DWIDTH*PIXCNT-1:0]   data_out,
    output logic                       data_vld,
    output logic                       busy,
    output logic                       frame_done,
    output logic [15:0]                stall_cnt
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = DWIDTH * PIXCNT;

    stream_state_t       state_q, state_d;
    logic [RW-1:0]       rows_q, rows_d, row_q, row_d;
    logic [CW-1:0]       beats_q, beats_d, beat_q, beat_d;
    logic [HB_WIDTH-1:0] hb_q, hb_d, blank_q, blank_d;
    logic [15:0]         stall_q, stall_d;
    logic [DW-1:0]       data_q;
    logic                vld_q, done_q;
    logic                hs, last_beat, last_row;

    assign s_ready    = state_q == LINE;
    assign hs         = s_valid & s_ready;
    assign last_beat  = beat_q == beats_q - CW'(1);
    assign last_row   = row_q == rows_q - RW'(1);
    assign new_frame  = state_q == SOF;
    assign busy       = state_q != IDLE;
    assign frame_done = done_q;
    assign data_out   = data_q;
    assign data_vld   = vld_q;
    assign stall_cnt  = stall_q;

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        beats_d = beats_q;
        hb_d    = hb_q;
        row_d   = row_q;
        beat_d  = beat_q;
        blank_d = blank_q;
        stall_d = stall_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d  = rowSize;
                    beats_d = CW'(beats_per_line(16'(colSize), 16'(PIXCNT)));
                    hb_d    = hblank;
                    row_d   = '0;
                    beat_d  = '0;
                    blank_d = '0;
                    stall_d = '0;
                    state_d = (rowSize != '0 && colSize != '0) ? SOF : DONE;
                end
            end
            SOF: state_d = LINE;
            LINE: begin
                if (!s_valid && stall_q != 16'hFFFF)
                    stall_d = stall_q + 16'd1;
                if (hs) begin
                    if (!last_beat) begin
                        beat_d = beat_q + CW'(1);
                    end else if (last_row) begin
                        state_d = DONE;
                    end else begin
                        beat_d = '0;
                        row_d  = row_q + RW'(1);
                        if (hb_q != '0) begin
                            state_d = HBLANK;
                            blank_d = hb_q;
                        end
                    end
                end
            end
            // blank_q counts down from hblank, so the gap is exactly hblank cycles
            HBLANK: begin
                blank_d = blank_q - HB_WIDTH'(1);
                state_d = (blank_q == HB_WIDTH'(1)) ? LINE : HBLANK;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            rows_q  <= '0;
            beats_q <= '0;
            hb_q    <= '0;
            row_q   <= '0;
            beat_q  <= '0;
            blank_q <= '0;
            stall_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            beats_q <= beats_d;
            hb_q    <= hb_d;
            row_q   <= row_d;
            beat_q  <= beat_d;
            blank_q <= blank_d;
            stall_q <= stall_d;
            vld_q   <= hs;
            done_q  <= state_q == DONE;
            if (hs)
                data_q <= s_data;
        end
    end

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: table-driven and randomized frames checked against a scoreboard
// built from frame geometry (beats, gaps, latency, stall and busy arithmetic).
module tb_frame_streamer;

    localparam int DWIDTH = 10, PIXCNT = 8, ROWS = 2048, COLS = 2448, HB_WIDTH = 8;
    localparam int DW = DWIDTH * PIXCNT, RW = 11, CW = 12;

    logic                sys_clk = 1'b0, sys_rst = 1'b1, start = 1'b0, s_valid = 1'b0;
    logic [RW-1:0]       rowSize = '0;
    logic [CW-1:0]       colSize = '0;
    logic [HB_WIDTH-1:0] hblank = '0;
    logic [DW-1:0]       s_data = '0, data_out;
    logic                s_ready, new_frame, data_vld, busy, frame_done;
    logic [15:0]         stall_cnt;
    int                  n_chk = 0, n_fail = 0;

    typedef struct {
        int rows; int cols; int hb; int pct; int stall_at; int stall_len; bit mid;
        int exp_beats; int exp_stall;
    } vec_t;
    vec_t tbl[7];

    always #5 sys_clk = ~sys_clk;

    frame_streamer #(.DWIDTH(DWIDTH), .PIXCNT(PIXCNT), .ROWS(ROWS), .COLS(COLS), .HB_WIDTH(HB_WIDTH)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .rowSize(rowSize), .colSize(colSize),
        .hblank(hblank), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .new_frame(new_frame),
        .data_out(data_out), .data_vld(data_vld), .busy(busy), .frame_done(frame_done), .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_new_frame"}, new_frame, 0);
        check({tag, "_data_vld"}, data_vld, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_stall_cnt"}, stall_cnt, 0);
    endtask

    task automatic run_frame(input vec_t v, output int beats, output int stall);
        int bpl, total, hs, gap, stalled, nf, last_hs, done_cyc, busy_n, stall_raw, budget, sat;
        bit in_gap, vv;
        logic [95:0] r;
        logic [DW-1:0] w;
        logic [DW-1:0] exp_q[$];
        bpl = (v.cols + PIXCNT - 1) / PIXCNT;
        total = (v.rows == 0 || v.cols == 0) ? 0 : v.rows * bpl;
        hs = 0; gap = 0; stalled = 0; nf = 0; last_hs = -10; done_cyc = -1;
        busy_n = 0; stall_raw = 0; beats = 0; in_gap = 0;
        budget = 500 + v.stall_len + 4 * total * (v.hb + 2);
        @(negedge sys_clk);
        start = 1'b1; rowSize = RW'(v.rows); colSize = CW'(v.cols); hblank = HB_WIDTH'(v.hb); s_valid = 1'b0;
        for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
            @(negedge sys_clk);
            start = 1'b0;
            if (cyc == 1) begin
                rowSize = RW'($urandom); colSize = CW'($urandom); hblank = HB_WIDTH'($urandom);
            end
            if (v.mid && cyc == 5) begin
                start = 1'b1; rowSize = RW'(v.rows + 3); colSize = CW'(v.cols + 40); hblank = HB_WIDTH'(v.hb + 4);
            end
            if (busy) busy_n++;
            if (new_frame) begin
                nf++;
                check("new_frame_cycle", cyc, 1);
            end
            if (data_vld) begin
                if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    w = exp_q.pop_front();
                    check("beat_data", data_out, w);
                end
                beats++;
            end
            if (frame_done) begin
                done_cyc = cyc;
                sat = stall_raw > 65535 ? 65535 : stall_raw;
                check("done_latency", cyc, total == 0 ? 2 : last_hs + 2);
                check("stall_cnt", stall_cnt, sat);
                check("busy_at_done", busy, 0);
            end else if (hs < total && cyc >= 2) begin
                if (in_gap) begin
                    if (s_ready) begin
                        check("hblank_gap", gap, v.hb);
                        in_gap = 0;
                    end else gap++;
                end else check("ready_in_line", s_ready, 1);
            end
            if (v.stall_len > 0 && hs >= v.stall_at && stalled < v.stall_len) begin
                vv = 1'b0;
                if (s_ready) stalled++;
            end else vv = $urandom_range(99) < v.pct;
            r = {$urandom, $urandom, $urandom};
            if (s_ready && !vv) stall_raw++;
            if (s_ready && vv) begin
                exp_q.push_back(r[DW-1:0]);
                hs++;
                last_hs = cyc;
                if (hs % bpl == 0 && hs < total && v.hb != 0) begin
                    in_gap = 1;
                    gap = 0;
                end
            end
            s_valid = vv;
            s_data = r[DW-1:0];
        end
        s_valid = 1'b0;
        if (done_cyc < 0) check("frame_done_timeout", 0, 1);
        check("beat_count", beats, total);
        check("new_frame_count", nf, total != 0);
        check("busy_cycles", busy_n, total == 0 ? 1 : 2 + total + stall_raw + (v.rows - 1) * v.hb);
        check("leftover_beats", exp_q.size(), 0);
        @(negedge sys_clk);
        check("done_single_pulse", frame_done, 0);
        check("busy_after_done", busy, 0);
        stall = stall_raw > 65535 ? 65535 : stall_raw;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b, s;
        vec_t rv;
        tbl[0] = '{4, 64, 3, 100, -1, 0, 1'b0, 32, 0};
        tbl[1] = '{2, 20, 0, 100, -1, 0, 1'b0, 6, 0};
        tbl[2] = '{1, 64, 0, 100, 3, 5, 1'b0, 8, 5};
        tbl[3] = '{0, 64, 2, 100, -1, 0, 1'b0, 0, 0};
        tbl[4] = '{3, 0, 2, 100, -1, 0, 1'b0, 0, 0};
        tbl[5] = '{3, 24, 2, 100, -1, 0, 1'b1, 9, 0};
        tbl[6] = '{1, 16, 0, 100, 1, 70000, 1'b0, 2, 65535};

        repeat (3) @(negedge sys_clk);
        check_idle_outputs("reset");
        sys_rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i], b, s);
            check("tbl_beats", b, tbl[i].exp_beats);
            check("tbl_stall", s, tbl[i].exp_stall);
        end

        // abort a frame in row 2 with an asynchronous reset
        @(negedge sys_clk);
        start = 1'b1; rowSize = RW'(4); colSize = CW'(32); hblank = HB_WIDTH'(2);
        @(negedge sys_clk);
        start = 1'b0; s_valid = 1'b1; s_data = {DW{1'b1}};
        repeat (14) @(negedge sys_clk);
        check("busy_before_reset", busy, 1);
        check("vld_before_reset", data_vld, 1);
        sys_rst = 1'b1;
        #1;
        check_idle_outputs("midframe_reset");
        @(negedge sys_clk);
        sys_rst = 1'b0; s_valid = 1'b0;
        repeat (4) begin
            @(negedge sys_clk);
            check("no_done_after_reset", frame_done, 0);
            check("idle_after_reset", busy, 0);
        end
        run_frame(tbl[0], b, s);
        check("post_reset_beats", b, 32);

        for (int i = 0; i < 8; i++) begin
            rv = '{$urandom_range(5, 1), $urandom_range(80, 1), $urandom_range(5, 0),
                   $urandom_range(100, 40), -1, 0, 1'b0, 0, 0};
            run_frame(rv, b, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
